// File: rtl/logic_pkg.sv
// Shared encodings for the bitwise reduction block: operation select and FSM states.
package logic_pkg;

  typedef enum logic [1:0] {
    OP_OR  = 2'b00,
    OP_AND = 2'b01,
    OP_XOR = 2'b10,
    OP_NOR = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ACCUM = 2'b01,
    HOLD  = 2'b10
  } state_t;

endpackage

// File: rtl/bitwise_op.sv
// Combinational two-operand bitwise gate, WIDTH-parametrised successor of the 16-bit gate blocks.
module bitwise_op
  import logic_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  op_t              op,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      OP_OR:   y = a | b;
      OP_AND:  y = a & b;
      OP_XOR:  y = a ^ b;
      OP_NOR:  y = ~(a | b);
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/logic_accum.sv
// Folds a valid/ready burst of words into one word with OR/AND/XOR/NOR and presents the
// registered result with its word count and a force-close overflow flag.
module logic_accum
  import logic_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int MAX_WORDS = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [1:0]                       op,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [WIDTH-1:0]                 in_data,
  input  logic                             in_last,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [WIDTH-1:0]                 out_data,
  output logic [$clog2(MAX_WORDS+1)-1:0]   out_count,
  output logic                             out_overflow
);

  localparam int CW = $clog2(MAX_WORDS + 1);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_WORDS);
  localparam logic [CW-1:0] ONE_C = CW'(1);

  state_t           state, next_state;
  logic             alive;
  op_t              op_q, fold_op, word_op;
  logic [WIDTH-1:0] acc, fold, word_acc, result;
  logic [CW-1:0]    cnt, cnt_next;
  logic             first, accept, close_burst, take;

  // alive keeps in_ready low until the first edge after reset release
  assign in_ready  = alive && (state != HOLD);
  assign out_valid = (state == HOLD);
  assign accept    = in_valid && in_ready;
  assign take      = (state == HOLD) && out_ready;
  assign first     = (state == IDLE);

  // NOR folds as OR; the single inversion happens when the result is captured
  assign fold_op  = (op_q == OP_NOR) ? OP_OR : op_q;

  bitwise_op #(.WIDTH(WIDTH)) u_fold (
    .a  (acc),
    .b  (in_data),
    .op (fold_op),
    .y  (fold)
  );

  assign word_acc    = first ? in_data : fold;
  assign word_op     = first ? op_t'(op) : op_q;
  assign cnt_next    = first ? ONE_C : cnt + ONE_C;
  assign close_burst = accept && (in_last || (cnt_next == MAX_C));
  assign result      = (word_op == OP_NOR) ? ~word_acc : word_acc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      alive <= 1'b0;
    end else begin
      state <= next_state;
      alive <= 1'b1;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (close_burst)  next_state = HOLD;
        else if (accept)  next_state = ACCUM;
      end
      ACCUM: begin
        if (close_burst)  next_state = HOLD;
      end
      HOLD: begin
        if (out_ready)    next_state = IDLE;
      end
      default:            next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc          <= '0;
      cnt          <= '0;
      op_q         <= OP_OR;
      out_data     <= '0;
      out_count    <= '0;
      out_overflow <= 1'b0;
    end else begin
      if (accept) begin
        acc <= word_acc;
        cnt <= cnt_next;
        if (first) op_q <= word_op;
      end
      if (close_burst) begin
        out_data     <= result;
        out_count    <= cnt_next;
        out_overflow <= !in_last;
      end else if (take) begin
        out_overflow <= 1'b0;
      end
    end
  end

endmodule
